// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared types and tick helpers for the button gesture controller
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    EVT_SINGLE,
    EVT_DOUBLE,
    EVT_LONG,
    EVT_REPEAT
  } evt_code_t;

  // Convert a duration in milliseconds to clock ticks.
  function automatic int ms_to_ticks(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Largest of three tick counts, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_event_slot.sv
// rtl/btn_event_slot.sv - one-deep valid/ready event holding register with drop pulse
import btn_event_pkg::*;

module btn_event_slot (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load_i,
  input  evt_code_t code_i,
  output logic      valid_o,
  output evt_code_t code_o,
  input  logic      ready_i,
  output logic      drop_o
);

  logic      valid_q;
  evt_code_t code_q;
  logic      drop_q;

  // Load when empty or being drained this cycle; otherwise keep the older event and flag the loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      code_q  <= EVT_SINGLE;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= load_i && valid_q && !ready_i;
      if (load_i && (!valid_q || ready_i)) begin
        valid_q <= 1'b1;
        code_q  <= code_i;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign code_o  = code_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - single/double/long-press classifier; BTN_EVENT_AUTO_REPEAT_EN adds hold repeat
import btn_event_pkg::*;

module btn_event_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int LONG_MS   = 600,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 150
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_db,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_drop,
  output logic       busy
);

  localparam int LONG_T = ms_to_ticks(CLK_HZ, LONG_MS);
  localparam int DBL_T  = ms_to_ticks(CLK_HZ, DOUBLE_MS);
  localparam int RPT_T  = ms_to_ticks(CLK_HZ, REPEAT_MS);
  localparam int MAX_T  = max3(LONG_T, DBL_T, RPT_T);
  localparam int TW     = $clog2(MAX_T) + 1;

  // A timeout compare at T-1 needs at least two ticks to be meaningful.
  if (LONG_T < 2 || DBL_T < 2 || RPT_T < 2) begin : g_bad_ticks
    $error("btn_event_ctrl: every tick constant must be at least 2");
  end

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            btn_q;
  logic            rise, fall;
  logic            emit;
  logic            timer_clr;
  evt_code_t       emit_code;
  evt_code_t       slot_code;

  assign rise = btn_db & ~btn_q;
  assign fall = ~btn_db & btn_q;

  // Previous button level; resets high so a button held through reset needs a release first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) btn_q <= 1'b1;
    else          btn_q <= btn_db;
  end

  // State and timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Gesture next-state and event emission; edges win over same-cycle timeouts.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = EVT_SINGLE;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = PRESS1;
      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
        end else if (timer_q == TW'(LONG_T - 1)) begin
          state_d   = HOLD;
          emit      = 1'b1;
          emit_code = EVT_LONG;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (timer_q == TW'(DBL_T - 1)) begin
          state_d   = IDLE;
          emit      = 1'b1;
          emit_code = EVT_SINGLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d   = IDLE;
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
        end
`ifdef BTN_EVENT_AUTO_REPEAT_EN
        else if (btn_db && timer_q == TW'(RPT_T - 1)) begin
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          timer_clr = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer restarts on any state entry or repeat, otherwise counts up and saturates.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q || timer_clr) timer_d = '0;
    else if (timer_q != '1)              timer_d = timer_q + TW'(1);
  end

  btn_event_slot u_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (emit),
    .code_i  (emit_code),
    .valid_o (evt_valid),
    .code_o  (slot_code),
    .ready_i (evt_ready),
    .drop_o  (evt_drop)
  );

  assign evt_code = slot_code;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - directed self-checking bench for btn_event_ctrl
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_db;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_drop;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int ev_cnt [0:3] = '{default: 0};
  int drop_cnt = 0;
  int base [0:3];
  int drop_base;

`ifdef BTN_EVENT_AUTO_REPEAT_EN
  localparam int EXP_REPEATS = 2;
`else
  localparam int EXP_REPEATS = 0;
`endif

  btn_event_ctrl #(
    .CLK_HZ    (1000),
    .LONG_MS   (10),
    .DOUBLE_MS (5),
    .REPEAT_MS (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_db    (btn_db),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .evt_drop  (evt_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Event scoreboard: handshakes and drop pulses counted mid-cycle.
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) ev_cnt[evt_code] = ev_cnt[evt_code] + 1;
    if (evt_drop) drop_cnt = drop_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) base[i] = ev_cnt[i];
    drop_base = drop_cnt;
  endtask

  function automatic int delta(input int i);
    return ev_cnt[i] - base[i];
  endfunction

  function automatic int total_delta();
    return delta(0) + delta(1) + delta(2) + delta(3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    btn_db    = 1'b0;
    evt_ready = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code",  32'(evt_code), 0);
    chk("rst_drop",  32'(evt_drop), 0);
    chk("rst_busy",  32'(busy), 0);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_busy", 32'(busy), 0);

    // Single click: WAIT2 entered 3 edges after press, SINGLE 5 edges later.
    snap();
    btn_db = 1'b1; cyc(1);
    chk("single_busy", 32'(busy), 1);
    cyc(2);
    btn_db = 1'b0; cyc(5);
    chk("single_early", 32'(evt_valid), 0);
    cyc(1);
    chk("single_valid", 32'(evt_valid), 1);
    chk("single_code",  32'(evt_code), 0);
    cyc(1);
    chk("single_clear", 32'(evt_valid), 0);
    chk("single_idle",  32'(busy), 0);
    cyc(5);
    chk("single_cnt", 32'(delta(0)), 1);
    chk("single_tot", 32'(total_delta()), 1);

    // Double click.
    snap();
    btn_db = 1'b1; cyc(3);
    btn_db = 1'b0; cyc(2);
    btn_db = 1'b1; cyc(3);
    btn_db = 1'b0; cyc(1);
    chk("double_valid", 32'(evt_valid), 1);
    chk("double_code",  32'(evt_code), 1);
    chk("double_idle",  32'(busy), 0);
    cyc(10);
    chk("double_cnt",  32'(delta(1)), 1);
    chk("double_nosg", 32'(delta(0)), 0);

    // Long press, held 20 cycles.
    snap();
    btn_db = 1'b1; cyc(10);
    chk("long_early", 32'(evt_valid), 0);
    cyc(1);
    chk("long_valid", 32'(evt_valid), 1);
    chk("long_code",  32'(evt_code), 2);
    chk("long_busy",  32'(busy), 1);
`ifdef BTN_EVENT_AUTO_REPEAT_EN
    cyc(4);
    chk("rpt_valid", 32'(evt_valid), 1);
    chk("rpt_code",  32'(evt_code), 3);
    cyc(5);
`else
    cyc(9);
`endif
    btn_db = 1'b0; cyc(1);
    chk("long_rel_valid", 32'(evt_valid), 0);
    chk("long_rel_idle",  32'(busy), 0);
    cyc(10);
    chk("long_cnt",   32'(delta(2)), 1);
    chk("long_nosg",  32'(delta(0)), 0);
    chk("long_rpts",  32'(delta(3)), EXP_REPEATS);

    // Release on the exact long-timeout cycle: fall wins.
    snap();
    btn_db = 1'b1; cyc(10);
    btn_db = 1'b0; cyc(1);
    chk("tie_long_valid", 32'(evt_valid), 0);
    chk("tie_long_busy",  32'(busy), 1);
    cyc(10);
    chk("tie_long_nolong", 32'(delta(2)), 0);
    chk("tie_long_single", 32'(delta(0)), 1);

    // Second press on the exact double-timeout cycle: rise wins.
    snap();
    btn_db = 1'b1; cyc(3);
    btn_db = 1'b0; cyc(5);
    btn_db = 1'b1; cyc(2);
    btn_db = 1'b0; cyc(1);
    chk("tie_dbl_valid", 32'(evt_valid), 1);
    chk("tie_dbl_code",  32'(evt_code), 1);
    cyc(8);
    chk("tie_dbl_nosg", 32'(delta(0)), 0);
    chk("tie_dbl_cnt",  32'(delta(1)), 1);

    // Backpressure: second single is dropped, first one kept.
    snap();
    evt_ready = 1'b0;
    btn_db = 1'b1; cyc(3);
    btn_db = 1'b0; cyc(6);
    chk("bp_first_valid", 32'(evt_valid), 1);
    chk("bp_first_drop",  32'(evt_drop), 0);
    btn_db = 1'b1; cyc(3);
    btn_db = 1'b0; cyc(6);
    chk("bp_drop",       32'(evt_drop), 1);
    chk("bp_hold_valid", 32'(evt_valid), 1);
    chk("bp_hold_code",  32'(evt_code), 0);
    cyc(1);
    chk("bp_drop_pulse", 32'(evt_drop), 0);
    chk("bp_drop_cnt",   32'(drop_cnt - drop_base), 1);
    evt_ready = 1'b1; cyc(1);
    chk("bp_drained", 32'(evt_valid), 0);
    cyc(3);
    chk("bp_single_cnt", 32'(delta(0)), 1);
    chk("bp_tot",        32'(total_delta()), 1);

    // Reset mid-gesture, then button held across reset release.
    snap();
    btn_db = 1'b1; cyc(4);
    chk("rm_busy", 32'(busy), 1);
    reset_n = 1'b0; #1;
    chk("rm_busy0",  32'(busy), 0);
    chk("rm_valid0", 32'(evt_valid), 0);
    chk("rm_drop0",  32'(evt_drop), 0);
    chk("rm_code0",  32'(evt_code), 0);
    cyc(3);
    reset_n = 1'b1; cyc(15);
    chk("held_busy", 32'(busy), 0);
    chk("held_none", 32'(total_delta()), 0);
    btn_db = 1'b0; cyc(2);
    chk("held_rel_busy", 32'(busy), 0);
    btn_db = 1'b1; cyc(1);
    chk("held_repress_busy", 32'(busy), 1);
    cyc(2);
    btn_db = 1'b0; cyc(10);
    chk("held_single", 32'(delta(0)), 1);
    chk("held_tot",    32'(total_delta()), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Gesture controller that sits downstream of the debouncer_fsm output and classifies the debounced button level into single-click, double-click and long-press events. Each event is delivered through a one-deep valid/ready output slot to a consumer such as a menu FSM or LED counter. With the optional feature enabled, a held button also emits periodic repeat events.

Parameters:
CLK_HZ, 100_000_000, clock frequency in Hz
LONG_MS, 600, press duration in ms that qualifies as a long press
DOUBLE_MS, 250, maximum release gap in ms for a second press to form a double-click
REPEAT_MS, 150, auto-repeat period in ms while held after a long press (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn_db  in  1  debounced button level, synchronous to clk
evt_valid  out  1  event slot occupied
evt_code  out  2  0=SINGLE, 1=DOUBLE, 2=LONG, 3=REPEAT
evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready
evt_drop  out  1  one-cycle pulse: an event was lost because the slot was full
busy  out  1  FSM not in IDLE

Behaviour:
- Tick constants: LONG_T = CLK_HZ/1000*LONG_MS, DBL_T = CLK_HZ/1000*DOUBLE_MS, RPT_T = CLK_HZ/1000*REPEAT_MS. Each must be ≥ 2; an elaboration-time assertion enforces this.
- Timer width: $clog2 of the largest constant + 1. The timer clears on every state entry and increments every cycle while in the state. It saturates; it never wraps.
- Edge detection: btn_reg is a registered copy of btn_db, reset to 1. rise = btn_db & ~btn_reg; fall = ~btn_db & btn_reg. Because btn_reg resets to 1, a button held through reset is ignored until it is released.
- States (btn_event_pkg::state_t):
  - IDLE: on rise, go to PRESS1.
  - PRESS1: on fall, go to WAIT2. Otherwise, when timer == LONG_T-1, emit LONG and go to HOLD. If fall and the timeout occur in the same cycle, fall wins.
  - WAIT2: on rise, go to PRESS2. Otherwise, when timer == DBL_T-1, emit SINGLE and go to IDLE. If rise and the timeout occur in the same cycle, rise wins.
  - PRESS2: on fall, emit DOUBLE and go to IDLE. No long-press detection in this state.
  - HOLD: on fall, go to IDLE. No event is emitted on this release.
- Emission timing: "emit" loads the slot on the same clock edge as the state transition. evt_valid is therefore high in the first cycle of the next state.
- Slot rules:
  - The slot holds its code until accepted.
  - A same-cycle accept and a new emit replace the slot contents; evt_valid stays 1.
  - An emit while the slot is full and not being accepted discards the new event (the older event is kept), and evt_drop pulses for 1 cycle.
- busy = (state != IDLE), derived combinationally from the state register.
- Reset values: evt_valid=0, evt_code=0, evt_drop=0, busy=0, state=IDLE, timer=0. Asserting reset mid-gesture aborts the gesture with no event. Reset release begins in IDLE.

Optional Feature:
Macro BTN_EVENT_AUTO_REPEAT_EN.
- Defined: in HOLD, when timer == RPT_T-1 while btn_db is high, emit REPEAT and clear the timer. A fall in that same cycle wins: go to IDLE, no REPEAT.
- Undefined: HOLD only waits for release, REPEAT is never produced, and REPEAT_MS is unused.

Decomposition:
- Package btn_event_pkg:
  - state_t enum {IDLE, PRESS1, WAIT2, PRESS2, HOLD}
  - evt_code_t enum {EVT_SINGLE, EVT_DOUBLE, EVT_LONG, EVT_REPEAT}
  - function ms_to_ticks(clk_hz, ms)
- One sub-module, btn_event_slot: the one-deep valid/ready holding register with drop detection. Its inputs are load/code and it exposes valid/code/ready/drop.
- Gesture FSM and timer stay in btn_event_ctrl.

Test Plan:
All scenarios use CLK_HZ=1000 so that 1 ms = 1 cycle, with LONG_MS=10, DOUBLE_MS=5, REPEAT_MS=4, and evt_ready=1 unless stated.
- Single: btn_db high 3 cycles then low → exactly one EVT_SINGLE, with evt_valid asserted 5 cycles after the WAIT2 entry. No other events.
- Double: high 3, low 2, high 3, low → one EVT_DOUBLE the cycle after the second fall. No SINGLE.
- Long: high 20 cycles → EVT_LONG asserted 10 cycles after PRESS1 entry, nothing on release. With BTN_EVENT_AUTO_REPEAT_EN: REPEAT at HOLD cycles 4 and 8.
- Tie cases:
  - Release on the exact cycle timer hits LONG_T-1 → WAIT2, no LONG.
  - Second press on the exact cycle WAIT2 times out → DOUBLE, no SINGLE.
- Backpressure: evt_ready=0, two single clicks → first SINGLE held, evt_drop pulses once. Raising evt_ready delivers the first SINGLE only.
- Reset/held: reset_n low mid-PRESS1 → all outputs 0, no event. btn_db held high across reset release → no event until a release followed by a new press.
